// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the shift-and-add multiplier datapath.
//   MULT_WIDTH_DEFAULT : default operand width
//   mult_cnt_t         : step counter type for the default width (0..WIDTH)
//   mult_ctl_t         : bundle of controller strobes {clr, ld, ldp, shp, shb}
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 4;

  typedef logic [$clog2(MULT_WIDTH_DEFAULT+1)-1:0] mult_cnt_t;

  typedef struct packed {
    logic clr;
    logic ld;
    logic ldp;
    logic shp;
    logic shb;
  } mult_ctl_t;

endpackage

// File: rtl/mult_acc_add.sv
// mult_acc_add
// Combinational (WIDTH+1)-bit conditional adder for the upper partial product.
// Ports:
//   p_hi [WIDTH-1:0] in  : current upper half of the partial product
//   a    [WIDTH-1:0] in  : multiplicand
//   b0               in  : current multiplier LSB, selects add or skip
//   sum  [WIDTH:0]   out : p_hi + (b0 ? a : 0), carry in the MSB
module mult_acc_add
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] p_hi,
  input  logic [WIDTH-1:0] a,
  input  logic             b0,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH-1:0] addend;

  // Skip the add entirely when the multiplier bit is zero.
  always_comb begin
    addend = b0 ? a : '0;
    sum    = {1'b0, p_hi} + {1'b0, addend};
  end

endmodule

// File: rtl/mult_datapath.sv
// mult_datapath
// Shift-and-add multiplier datapath driven by controller strobes. Holds the
// multiplicand A, multiplier B, partial product P (with carry bit) and a step
// counter. After WIDTH product shifts it freezes and registers the product.
// Ports:
//   clk, reset (async, active-high)
//   clr, ld, ldp, shp, shb : controller strobes
//   a_in, b_in  [WIDTH-1:0]   : operands (unsigned)
//   prod_out    [2*WIDTH-1:0] : registered final product
//   prod_valid                : prod_out holds a completed product
//   err                       : sticky protocol error
// Build option: define MULT_DP_ERR_EN to build the protocol error detector;
// otherwise err is tied to 0.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 ld,
  input  logic                 ldp,
  input  logic                 shp,
  input  logic                 shb,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [2*WIDTH-1:0]   prod_out,
  output logic                 prod_valid,
  output logic                 err
);

  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  mult_ctl_t ctl;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [2*WIDTH:0] p_reg;
  logic [CNT_W-1:0] cnt;
  logic             frozen;

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] p_add;
  logic [2*WIDTH:0] p_next;

  assign ctl = '{clr: clr, ld: ld, ldp: ldp, shp: shp, shb: shb};

  mult_acc_add #(.WIDTH(WIDTH)) u_add (
    .p_hi (p_reg[2*WIDTH-1:WIDTH]),
    .a    (a_reg),
    .b0   (b_reg[0]),
    .sum  (sum)
  );

  // Add first, then shift, so a combined ldp+shp is a single step.
  always_comb begin
    frozen = (cnt == CNT_DONE);
    p_add  = ctl.ldp ? {sum, p_reg[WIDTH-1:0]} : p_reg;
    p_next = ctl.shp ? (p_add >> 1) : p_add;
  end

  // ld is written after shb so a simultaneous load wins on B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      p_reg      <= '0;
      cnt        <= '0;
      prod_out   <= '0;
      prod_valid <= 1'b0;
    end else if (ctl.clr) begin
      a_reg      <= '0;
      b_reg      <= '0;
      p_reg      <= '0;
      cnt        <= '0;
      prod_out   <= '0;
      prod_valid <= 1'b0;
    end else begin
      if (!frozen) begin
        p_reg <= p_next;
        if (ctl.shb) begin
          b_reg <= b_reg >> 1;
        end
        if (ctl.shp) begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            prod_out   <= p_next[2*WIDTH-1:0];
            prod_valid <= 1'b1;
          end
        end
      end
      if (ctl.ld) begin
        a_reg <= a_in;
        b_reg <= b_in;
      end
    end
  end

`ifdef MULT_DP_ERR_EN
  // Sticky flag: reload mid-operation, or arithmetic strobes after completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (ctl.clr) begin
      err <= 1'b0;
    end else if ((ctl.ld && (cnt != '0) && !frozen) ||
                 ((ctl.ldp || ctl.shp) && frozen)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Shift-and-add multiplier datapath driven by the sequencing controller's strobes (`clr`, `ld`, `ldp`, `shp`, `shb`). It holds the multiplicand, the multiplier and the partial product, and performs one add-or-skip per `ldp` and one right shift per `shp`/`shb`. After WIDTH product shifts it freezes, registers the final product and raises `prod_valid`. It sits directly downstream of the controller and feeds the result consumer.

## Interface
- `WIDTH`, default 4: operand width in bits. Product width is 2*WIDTH.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: reset, asynchronous and active-high.
- `clr`  in  1: clear strobe.
- `ld`  in  1: load operands.
- `ldp`  in  1: conditional add into the upper partial product.
- `shp`  in  1: shift the partial product right.
- `shb`  in  1: shift the multiplier right.
- `a_in`  in  WIDTH: multiplicand, unsigned.
- `b_in`  in  WIDTH: multiplier, unsigned.
- `prod_out`  out  2*WIDTH: registered final product.
- `prod_valid`  out  1: `prod_out` holds a completed product.
- `err`  out  1: sticky protocol error (see Configuration).

## Operation
- Registers:
  - A[WIDTH-1:0]
  - B[WIDTH-1:0]
  - P[2*WIDTH:0], with P[2*WIDTH] as the carry bit
  - step count CNT, 0..WIDTH
  - `prod_out`, `prod_valid`
- `clr`: P, A, B, CNT, `prod_out` and `prod_valid` are cleared to 0. `clr` overrides every other strobe in the same cycle.
- `ld`: A<=`a_in`, B<=`b_in`. Does not touch P or CNT.
- `ldp`: P[2W:W] <= P[2W-1:W] + (B[0] ? A : 0). This is a (W+1)-bit result, so the carry lands in P[2W].
- `shp`: P <= P >> 1, with zero fill. CNT increments.
- `shb`: B <= B >> 1, with zero fill.
- Simultaneous strobes combine within one edge. All of them use the pre-edge register values.
  - `ldp`+`shp`: the add is applied first, then the shift: P <= (added P) >> 1. This counts as one step.
  - `ldp`+`shb`: `ldp` uses the old B[0].
  - `shp`+`shb`: both shifts apply independently.
  - `ld` with any other strobe: the loads apply, and `ldp` uses the old A/B.
- Completion: on the edge where `shp` is applied with CNT==WIDTH-1:
  - CNT becomes WIDTH.
  - `prod_out` <= the post-shift P[2W-1:0].
  - `prod_valid` <= 1.
- Freeze: while CNT==WIDTH, `ldp`, `shp` and `shb` are ignored. `prod_out` and `prod_valid` hold until `clr` or `reset`.
- `ld` while frozen updates A/B but does not clear `prod_valid`. Only `clr` starts a new operation.
- The product is mathematically A*B of the loaded operands when each step is issued as `ldp`, then `shp`, with `shb` issued after each `ldp`.

## Timing
- Every output is registered. Reset value of every output is 0: `prod_out`=0, `prod_valid`=0, `err`=0.
- Strobes are sampled on the rising edge, and the effect is visible the following cycle.
- `prod_valid` rises on the same edge as the WIDTH-th `shp`. There is no extra latency cycle.
- Reset asserted mid-operation immediately clears all registers, independent of the clock. The operation is abandoned, and a `clr` plus `ld` is required afterwards.
- Strobes held high for multiple cycles act once per edge.

## Configuration
- `MULT_DP_ERR_EN` defined: `err` is set on any edge where either of these occurs:
  - `ld` arrives while 0<CNT<WIDTH (reload mid-operation);
  - `ldp` or `shp` arrives while CNT==WIDTH.
- Once set, `err` is cleared only by `clr` or `reset`. The data behaviour is unchanged; ignored strobes are still ignored.
- `MULT_DP_ERR_EN` undefined: `err` is tied to constant 0, and no error logic is built.

## Structure
- Package `mult_pkg` holds:
  - `MULT_WIDTH_DEFAULT` = 4
  - typedef `mult_cnt_t`, sized $clog2(WIDTH+1)
  - the strobe-bundle struct typedef `mult_ctl_t` {clr, ld, ldp, shp, shb}
- One sub-module, `mult_acc_add`. It is the combinational (W+1)-bit conditional adder: inputs P[2W-1:W], A and B[0]; output the sum with carry. The top level holds all registers, the counter, the freeze logic and the err logic.

## Test plan
- WIDTH=4, `clr`, `ld` with a=13, b=11, then 4×(`ldp`, `shp`, `shb`) -> `prod_valid`=1 on the 4th `shp` edge, with `prod_out`=143.
- a=15, b=15 with `ldp`+`shp` combined in the same cycle and `shb` alongside -> `prod_out`=225. Checks that the carry bit P[8] is propagated.
- After completion, hold `shp`+`shb` high for 5 cycles -> `prod_out` stays 143 and CNT stays 4. With `MULT_DP_ERR_EN` defined, `err`=1; without it, `err`=0.
- `reset` pulsed asynchronously between clock edges after 2 steps -> all outputs 0 immediately. A fresh `clr`/`ld` 6×9 sequence then yields 54.
- `ld` after 2 steps, with the macro defined -> `err`=1 on the next edge. A subsequent `clr` -> `err`=0 and `prod_valid`=0.
- a=0, b=9 and a=9, b=0 -> `prod_out`=0 with `prod_valid`=1 after 4 steps.
